// File: rtl/mode_switch_arbiter_pkg.sv
// Shared types and helpers for the player-engine mode arbiter.
// Holds the arbitration state encoding, the well-known mode numbers and the one-hot helper.
package mode_switch_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MUTE = 1'b1
    } arb_state_e;

    localparam int MODE_FREE  = 0;
    localparam int MODE_AUTO  = 1;
    localparam int MODE_LEARN = 2;

    // Bit idx of a one-hot vector whose hot position is sel.
    function automatic logic onehot_bit(input int unsigned sel, input int unsigned idx);
        logic hit_s;
        if (sel == idx) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/mode_switch_arbiter_select_debouncer.sv
// Two-flop synchroniser, range mapping and stability filter for the raw mode switches.
// Out-of-range selects fall back to the free-play mode before the stability filter.
module select_debouncer
    import mode_switch_arbiter_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SEL_W         = 3,
    parameter int STABLE_CYCLES = 16,
    localparam int MODE_W       = $clog2(NUM_MODES),
    localparam int CNT_W        = $clog2(STABLE_CYCLES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  mode_select,
    output logic [MODE_W-1:0] cand,
    output logic              stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEL_W-1:0]  sync1_r;
    logic [SEL_W-1:0]  sync2_r;
    logic [31:0]       sel_ext_s;
    logic [MODE_W-1:0] mapped_s;
    logic [MODE_W-1:0] cand_r;
    logic [CNT_W-1:0]  cnt_r;

    // Range check of the synchronised select.
    always_comb begin
        sel_ext_s = 32'(sync2_r);
        if (sel_ext_s < 32'(NUM_MODES)) begin
            mapped_s = sel_ext_s[MODE_W-1:0];
        end else begin
            mapped_s = MODE_W'(MODE_FREE);
        end
    end

    // Synchroniser flops and the candidate/run-length tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {SEL_W{1'b0}};
            sync2_r <= {SEL_W{1'b0}};
            cand_r  <= {MODE_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= mode_select;
            sync2_r <= sync1_r;
            if (mapped_s != cand_r) begin
                cand_r <= mapped_s;
                cnt_r  <= {CNT_W{1'b0}};
            end else if (cnt_r < CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign cand   = cand_r;
    assign stable = (cnt_r == CNT_MAX);

endmodule

// File: rtl/mode_switch_arbiter.sv
// Selects one player engine to drive the speaker and LEDs, with debounced mode
// switches and a muted, click-free handover whenever the committed mode changes.
module mode_switch_arbiter
    import mode_switch_arbiter_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SEL_W         = 3,
    parameter int LED_W         = 7,
    parameter int STABLE_CYCLES = 16,
    parameter int MUTE_CYCLES   = 32,
    localparam int MODE_W       = $clog2(NUM_MODES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SEL_W-1:0]           mode_select,
    input  logic [NUM_MODES-1:0]       speaker_in,
    input  logic [NUM_MODES*LED_W-1:0] led_in,
    output logic                       speaker,
    output logic [LED_W-1:0]           led,
    output logic [MODE_W-1:0]          current_mode,
    output logic [NUM_MODES-1:0]       mode_enable,
    output logic                       switching
);

    localparam int MUTE_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [MUTE_W-1:0] MUTE_LAST = MUTE_W'(MUTE_CYCLES - 1);

    arb_state_e         state_r, state_n_s;
    logic [MODE_W-1:0]  mode_r, mode_n_s;
    logic [MODE_W-1:0]  target_r, target_n_s;
    logic [MUTE_W-1:0]  mute_cnt_r, mute_cnt_n_s;
    logic               speaker_r, speaker_n_s;
    logic [LED_W-1:0]   led_r, led_n_s;
    logic [NUM_MODES-1:0] enable_r, enable_n_s;
    logic               switching_r, switching_n_s;
    logic [MODE_W-1:0]  cand_s;
    logic               stable_s;

    select_debouncer #(
        .NUM_MODES     (NUM_MODES),
        .SEL_W         (SEL_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_select_debouncer (
        .clk         (clk),
        .reset       (reset),
        .mode_select (mode_select),
        .cand        (cand_s),
        .stable      (stable_s)
    );

    // Next-state logic and the next values of all registered outputs.
    always_comb begin
        state_n_s    = state_r;
        mode_n_s     = mode_r;
        target_n_s   = target_r;
        mute_cnt_n_s = mute_cnt_r;
        speaker_n_s  = 1'b0;
        led_n_s      = {LED_W{1'b0}};
        case (state_r)
            ST_RUN: begin
                speaker_n_s = speaker_in[mode_r];
                led_n_s     = led_in[int'(mode_r)*LED_W +: LED_W];
                if (stable_s && (cand_s != mode_r)) begin
                    state_n_s    = ST_MUTE;
                    target_n_s   = cand_s;
                    mute_cnt_n_s = {MUTE_W{1'b0}};
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_MUTE: begin
                // Target was latched on entry; select activity now waits for the next RUN.
                if (mute_cnt_r == MUTE_LAST) begin
                    state_n_s = ST_RUN;
                    mode_n_s  = target_r;
                end else begin
                    mute_cnt_n_s = mute_cnt_r + MUTE_W'(1);
                end
            end
            default: begin
                state_n_s = ST_RUN;
            end
        endcase

        // Enables and switching flag track the next state so they register without lag.
        if (state_n_s == ST_MUTE) begin
            switching_n_s = 1'b1;
        end else begin
            switching_n_s = 1'b0;
        end
        for (int i = 0; i < NUM_MODES; i++) begin
            if (state_n_s == ST_MUTE) begin
                enable_n_s[i] = 1'b0;
            end else begin
                enable_n_s[i] = onehot_bit(int'(mode_n_s), i);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            mode_r      <= MODE_W'(MODE_FREE);
            target_r    <= MODE_W'(MODE_FREE);
            mute_cnt_r  <= {MUTE_W{1'b0}};
            speaker_r   <= 1'b0;
            led_r       <= {LED_W{1'b0}};
            enable_r    <= NUM_MODES'(1);
            switching_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            mode_r      <= mode_n_s;
            target_r    <= target_n_s;
            mute_cnt_r  <= mute_cnt_n_s;
            speaker_r   <= speaker_n_s;
            led_r       <= led_n_s;
            enable_r    <= enable_n_s;
            switching_r <= switching_n_s;
        end
    end

    assign speaker      = speaker_r;
    assign led          = led_r;
    assign current_mode = mode_r;
    assign mode_enable  = enable_r;
    assign switching    = switching_r;

endmodule

// File: tb/tb_mode_switch_arbiter.sv
// Directed bench for mode_switch_arbiter: a cycle model of the switch/debounce/mute
// behaviour is checked every cycle, plus hand-computed checkpoints on key edges.
module tb_mode_switch_arbiter;

    localparam int NM = 4;
    localparam int SW = 3;
    localparam int LW = 7;
    localparam int SC = 4;
    localparam int MC = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [SW-1:0]   mode_select;
    logic [NM-1:0]   speaker_in;
    logic [NM*LW-1:0] led_in;
    logic            speaker;
    logic [LW-1:0]   led;
    logic [1:0]      current_mode;
    logic [NM-1:0]   mode_enable;
    logic            switching;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: the select pipeline, run length of the mapped value, handover progress
    int m_s1, m_s2, m_cand, m_run, m_left, m_target, m_mode, m_spk, m_led;
    bit m_muting, m_valid;

    mode_switch_arbiter #(
        .NUM_MODES     (NM),
        .SEL_W         (SW),
        .LED_W         (LW),
        .STABLE_CYCLES (SC),
        .MUTE_CYCLES   (MC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_select  (mode_select),
        .speaker_in   (speaker_in),
        .led_in       (led_in),
        .speaker      (speaker),
        .led          (led),
        .current_mode (current_mode),
        .mode_enable  (mode_enable),
        .switching    (switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: advances on each rising edge, then compares 1 time unit later.
    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_s1 = 0; m_s2 = 0; m_cand = 0; m_run = 0;
                m_muting = 1'b0; m_left = 0; m_target = 0; m_mode = 0;
                m_spk = 0; m_led = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                int mapped;
                bit settled;
                mapped  = (m_s2 < NM) ? m_s2 : 0;
                settled = (m_run >= SC - 1);
                if (!m_muting) begin
                    m_spk = int'(speaker_in[m_mode]);
                    m_led = int'(led_in[m_mode*LW +: LW]);
                    if (settled && m_cand != m_mode) begin
                        m_muting = 1'b1;
                        m_left   = MC;
                        m_target = m_cand;
                    end
                end else begin
                    m_spk  = 0;
                    m_led  = 0;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_muting = 1'b0;
                        m_mode   = m_target;
                    end
                end
                if (mapped != m_cand) begin
                    m_cand = mapped;
                    m_run  = 0;
                end else if (m_run < SC - 1) begin
                    m_run = m_run + 1;
                end
                m_s2 = m_s1;
                m_s1 = int'(mode_select);
            end
            #1;
            if (m_valid) begin
                check("model_speaker", 32'(speaker), 32'(m_spk));
                check("model_led", 32'(led), 32'(m_led));
                check("model_mode", 32'(current_mode), 32'(m_mode));
                check("model_enable", 32'(mode_enable), m_muting ? 32'd0 : (32'd1 << m_mode));
                check("model_switching", 32'(switching), 32'(m_muting));
            end
        end
    end

    // Directed stimulus with literal checkpoints (STABLE=4, MUTE=8).
    initial begin
        reset       = 1'b1;
        mode_select = 3'd0;
        speaker_in  = 4'b0101;
        led_in      = {7'h4D, 7'h2A, 7'h55, 7'h33};
        go(3);
        reset = 1'b0;

        // 1: idle in free mode
        go(8);
        check("t1_mode", 32'(current_mode), 32'd0);
        check("t1_enable", 32'(mode_enable), 32'h1);
        check("t1_speaker", 32'(speaker), 32'd1);
        check("t1_led", 32'(led), 32'h33);
        check("t1_switching", 32'(switching), 32'd0);

        // 2: 0 -> 2 handover
        mode_select = 3'd2;
        go(6);
        check("t2_no_switch_edge6", 32'(switching), 32'd0);
        go(1);
        check("t2_switch_edge7", 32'(switching), 32'd1);
        check("t2_enable_edge7", 32'(mode_enable), 32'h0);
        go(1);
        check("t2_speaker_muted", 32'(speaker), 32'd0);
        check("t2_led_muted", 32'(led), 32'h0);
        go(6);
        check("t2_still_mute_edge14", 32'(switching), 32'd1);
        check("t2_mode_edge14", 32'(current_mode), 32'd0);
        go(1);
        check("t2_mode_edge15", 32'(current_mode), 32'd2);
        check("t2_enable_edge15", 32'(mode_enable), 32'h4);
        check("t2_switch_edge15", 32'(switching), 32'd0);
        go(1);
        check("t2_speaker", 32'(speaker), 32'd1);
        check("t2_led", 32'(led), 32'h2A);
        go(3);

        // 3: short glitch toward mode 1 from mode 2
        mode_select = 3'd1;
        go(3);
        mode_select = 3'd2;
        go(20);
        check("t3_mode", 32'(current_mode), 32'd2);
        check("t3_switching", 32'(switching), 32'd0);

        // 4: out-of-range select falls back to mode 0
        mode_select = 3'd5;
        go(14);
        check("t4_mute_edge14", 32'(switching), 32'd1);
        check("t4_mode_edge14", 32'(current_mode), 32'd2);
        go(1);
        check("t4_mode_edge15", 32'(current_mode), 32'd0);
        check("t4_enable_edge15", 32'(mode_enable), 32'h1);
        go(5);

        // 5: select moves to 3 during handover toward 1
        mode_select = 3'd1;
        go(7);
        check("t5_switch_edge7", 32'(switching), 32'd1);
        go(2);
        mode_select = 3'd3;
        go(6);
        check("t5_mode_edge15", 32'(current_mode), 32'd1);
        check("t5_enable_edge15", 32'(mode_enable), 32'h2);
        check("t5_run_edge15", 32'(switching), 32'd0);
        go(1);
        check("t5_switch_edge16", 32'(switching), 32'd1);
        go(8);
        check("t5_mode_edge24", 32'(current_mode), 32'd3);
        check("t5_enable_edge24", 32'(mode_enable), 32'h8);
        go(1);
        check("t5_speaker", 32'(speaker), 32'd0);
        check("t5_led", 32'(led), 32'h4D);
        go(3);

        // 6: reset in the middle of a handover
        mode_select = 3'd2;
        go(10);
        check("t6_muting_before_reset", 32'(switching), 32'd1);
        reset = 1'b1;
        go(1);
        check("t6_switching", 32'(switching), 32'd0);
        check("t6_mode", 32'(current_mode), 32'd0);
        check("t6_enable", 32'(mode_enable), 32'h1);
        check("t6_speaker", 32'(speaker), 32'd0);
        reset = 1'b0;
        mode_select = 3'd0;
        go(20);
        check("t6_final_mode", 32'(current_mode), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
